// File: rtl/puneh_mem_arbiter.sv
// puneh_mem_arbiter: shares PUNEH's single-port memory between the CPU controller and the DMA/debug loader.
// Define PUNEH_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the CPU wins every tie.
module puneh_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_rd,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_dma,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       cpu_req;
  logic       dma_req;
  logic       pick_dma;

  assign cpu_req = cpu_rd | cpu_wr;
  assign dma_req = dma_rd | dma_wr;

`ifdef PUNEH_ARB_ROUND_ROBIN_EN
  // last_grant=1 means DMA won the previous access, so a tie now goes to the CPU
  logic last_grant;
  assign pick_dma = dma_req & (~cpu_req | ~last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (state == RESP) begin
      last_grant <= gnt_dma;
    end
  end
`else
  assign pick_dma = dma_req & ~cpu_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      dma_rdata <= '0;
      dma_ready <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_dma   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            // rd+wr together is a write, so the read strobe requires wr low
            gnt_dma   <= pick_dma;
            mem_addr  <= pick_dma ? dma_addr : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            mem_wr    <= pick_dma ? dma_wr : cpu_wr;
            mem_rd    <= pick_dma ? (dma_rd & ~dma_wr) : (cpu_rd & ~cpu_wr);
            cnt       <= 4'(WAIT_CYC);
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (mem_rd) begin
              if (gnt_dma) dma_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            cpu_ready <= ~gnt_dma;
            dma_ready <= gnt_dma;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          cpu_ready <= 1'b0;
          dma_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puneh_mem_arbiter.sv
// Scoreboard bench for puneh_mem_arbiter: per-requester expected-rdata queues fed by a reference memory,
// a memory-side monitor and a ready monitor. Expectations follow PUNEH_ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_puneh_mem_arbiter;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int WAIT_CYC = 1;
  localparam int TIMEOUT  = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_rd = 1'b0, cpu_wr = 1'b0, dma_rd = 1'b0, dma_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              cpu_ready, dma_ready;
  logic              mem_rd, mem_wr, gnt_dma, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  puneh_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_dma(gnt_dma), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int passCount  = 0;
  int checkCount = 0;

  // CPU traffic uses addresses with bit 9 clear, DMA traffic bit 9 set, so the two never alias
  logic [DATA_W-1:0] memArr[int];
  logic [DATA_W-1:0] refMem[int];
  logic [DATA_W-1:0] cpuQ[$];
  logic [DATA_W-1:0] dmaQ[$];
  logic [DATA_W-1:0] cpuLast = '0;
  logic [DATA_W-1:0] dmaLast = '0;
  bit                grantLog[$];
  int                readyCycleLog[$];
  int                burstStartLog[$];

  function automatic logic [DATA_W-1:0] initPat(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s (cycle %0d)", name, cycle);
  endtask

  task automatic driveReq(input bit isDma, input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (isDma) begin
      dma_rd = rd; dma_wr = wr; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Reference model: an ideal memory plus "rdata keeps the last read value" per requester
  task automatic applyStimulus(input bit isDma, input bit rd, input bit wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] expRdata;
    if (wr) begin
      refMem[int'(addr)] = wdata;
      expRdata = isDma ? dmaLast : cpuLast;
    end else begin
      expRdata = refMem.exists(int'(addr)) ? refMem[int'(addr)] : initPat(int'(addr));
      if (isDma) dmaLast = expRdata;
      else       cpuLast = expRdata;
    end
    if (isDma) dmaQ.push_back(expRdata);
    else       cpuQ.push_back(expRdata);
    driveReq(isDma, rd, wr, addr, wdata);
  endtask

  task automatic waitReady(input bit isDma);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(isDma ? dma_ready : cpu_ready) && n < TIMEOUT);
    if (!(isDma ? dma_ready : cpu_ready)) failNow(isDma ? "dma_ready timeout" : "cpu_ready timeout");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] randAddr(input bit isDma);
    logic [ADDR_W-1:0] a;
    a = 12'($urandom);
    a[9] = isDma;
    return a;
  endfunction

  task automatic runBurst(input bit isDma, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(isDma, 1'b1, 1'b0, randAddr(isDma), '0);
      waitReady(isDma);
    end
    driveReq(isDma, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic runRandom(input bit isDma, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 2));
      applyStimulus(isDma, op != 1, op != 0, randAddr(isDma), 16'($urandom));
      waitReady(isDma);
      driveReq(isDma, 1'b0, 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cpu_rdata"}, 32'(cpu_rdata), 0);
    checkOutput({tag, " dma_rdata"}, 32'(dma_rdata), 0);
    checkOutput({tag, " cpu_ready"}, 32'(cpu_ready), 0);
    checkOutput({tag, " dma_ready"}, 32'(dma_ready), 0);
    checkOutput({tag, " mem_rd"}, 32'(mem_rd), 0);
    checkOutput({tag, " mem_wr"}, 32'(mem_wr), 0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 0);
    checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    checkOutput({tag, " gnt_dma"}, 32'(gnt_dma), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
  endtask

  // Memory macro model: data is presented from mid-cycle onwards, writes land during the strobe
  always @(negedge clk) begin
    if (mem_wr && !rst) memArr[int'(mem_addr)] = mem_wdata;
    if (mem_rd && !rst)
      mem_rdata <= memArr.exists(int'(mem_addr)) ? memArr[int'(mem_addr)] : initPat(int'(mem_addr));
    else
      mem_rdata <= '0;
  end

  // Memory-side monitor: strobe contents match the owner's request, length WAIT_CYC+1, ready follows
  int                burstLen = 0;
  logic [ADDR_W-1:0] burstAddr = '0;
  bit                burstOwner = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      burstLen = 0;
    end else if (mem_rd || mem_wr) begin
      if (mem_rd && mem_wr) failNow("mem_rd and mem_wr both high");
      if (burstLen == 0) begin
        burstStartLog.push_back(cycle);
        burstAddr  = mem_addr;
        burstOwner = mem_addr[9];
        checkOutput("gnt_dma owner", 32'(gnt_dma), 32'(burstOwner));
        checkOutput("mem_addr", 32'(mem_addr), 32'(burstOwner ? dma_addr : cpu_addr));
        checkOutput("mem_wr op", 32'(mem_wr), 32'(burstOwner ? dma_wr : cpu_wr));
        checkOutput("mem_rd op", 32'(mem_rd), 32'(burstOwner ? (dma_rd & ~dma_wr) : (cpu_rd & ~cpu_wr)));
        if (burstOwner ? dma_wr : cpu_wr)
          checkOutput("mem_wdata", 32'(mem_wdata), 32'(burstOwner ? dma_wdata : cpu_wdata));
      end else begin
        checkOutput("mem_addr stable", 32'(mem_addr), 32'(burstAddr));
      end
      burstLen++;
    end else if (burstLen != 0) begin
      checkOutput("strobe length", 32'(burstLen), WAIT_CYC + 1);
      checkOutput("owner ready after strobe", 32'(burstOwner ? dma_ready : cpu_ready), 1);
      checkOutput("loser ready after strobe", 32'(burstOwner ? cpu_ready : dma_ready), 0);
      burstLen = 0;
    end
  end

  // Ready monitor: every pulse pops the owner's queue and compares read data
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ready) begin
        grantLog.push_back(1'b0);
        readyCycleLog.push_back(cycle);
        if (cpuQ.size() == 0) failNow("unexpected cpu_ready");
        else checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(cpuQ.pop_front()));
      end
      if (dma_ready) begin
        grantLog.push_back(1'b1);
        readyCycleLog.push_back(cycle);
        if (dmaQ.size() == 0) failNow("unexpected dma_ready");
        else checkOutput("dma_rdata", 32'(dma_rdata), 32'(dmaQ.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit expDma;
    // Reset values
    repeat (3) @(negedge clk);
    checkAllZero("in reset");
    #2 rst = 1'b0;
    @(negedge clk);
    checkAllZero("after reset");

    // Reset asserted mid-access aborts without a ready pulse
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h1A0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd && n < 20);
    checkOutput("abort strobe reached", 32'(mem_rd), 1);
    #2 rst = 1'b1;
    driveReq(1'b0, 1'b0, 1'b0, '0, '0);
    cpuQ.delete();
    cpuLast = '0;
    dmaLast = '0;
    #1;
    checkOutput("abort mem_rd drops", 32'(mem_rd), 0);
    checkOutput("abort mem_wr drops", 32'(mem_wr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post-abort cpu_ready", 32'(cpu_ready), 0);
      checkOutput("post-abort busy", 32'(busy), 0);
    end
    checkAllZero("post-abort");

    // CPU write, DMA write, CPU rd+wr together
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h012, 16'hBEEF);
    waitReady(1'b0);
    driveReq(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h3FF, 16'h1234);
    waitReady(1'b1);
    driveReq(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h055, 16'hA5A5);
    waitReady(1'b0);
    driveReq(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // Cycle-exact latency of a lone CPU read
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h012, '0);
    for (int i = 1; i <= WAIT_CYC + 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("latency mem_rd c%0d", i), 32'(mem_rd), 32'(i >= 2 && i <= WAIT_CYC + 2));
      checkOutput($sformatf("latency cpu_ready c%0d", i), 32'(cpu_ready), 32'(i == WAIT_CYC + 3));
      checkOutput($sformatf("latency busy c%0d", i), 32'(busy), 32'(i >= 2));
    end
    checkOutput("read-back cpu_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    @(posedge clk); #1;
    driveReq(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // Both requesters continuously busy; the previous grant went to the CPU
    grantLog.delete();
    readyCycleLog.delete();
    fork
      runBurst(1'b0, 4);
      runBurst(1'b1, 4);
    join
    checkOutput("burst grant count", 32'(grantLog.size()), 8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
`ifdef PUNEH_ARB_ROUND_ROBIN_EN
      expDma = (i % 2 == 0);
`else
      expDma = (i >= 4);
`endif
      checkOutput($sformatf("burst grant %0d", i), 32'(grantLog[i]), 32'(expDma));
      if (i > 0 && i < readyCycleLog.size())
        checkOutput($sformatf("burst period %0d", i), 32'(readyCycleLog[i] - readyCycleLog[i-1]), WAIT_CYC + 3);
    end
    @(posedge clk); #1;

    // DMA arrives while the CPU access is in progress
    grantLog.delete();
    readyCycleLog.delete();
    burstStartLog.delete();
    fork
      begin
        applyStimulus(1'b0, 1'b1, 1'b0, randAddr(1'b0), '0);
        waitReady(1'b0);
        driveReq(1'b0, 1'b0, 1'b0, '0, '0);
      end
      begin
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, randAddr(1'b1), 16'h0F0F);
        waitReady(1'b1);
        driveReq(1'b1, 1'b0, 1'b0, '0, '0);
      end
    join
    if (grantLog.size() == 2 && burstStartLog.size() == 2) begin
      checkOutput("late dma first grant", 32'(grantLog[0]), 0);
      checkOutput("late dma start", 32'(burstStartLog[1]), 32'(readyCycleLog[0] + 2));
    end else begin
      failNow("late dma log sizes");
    end
    @(posedge clk); #1;

    // Randomized concurrent traffic
    fork
      runRandom(1'b0, 40);
      runRandom(1'b1, 40);
    join
    repeat (4) @(negedge clk);
    checkOutput("cpu queue drained", 32'(cpuQ.size()), 0);
    checkOutput("dma queue drained", 32'(dmaQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
